// File: rtl/ic_bvuge_bvand_checker.sv
// Serial checker for the invertibility condition of (x & s) >=u t.
// Runs two MSB-first unsigned compares, bit-serially, and keeps saturating counters of checks and errors.
module ic_bvuge_bvand_checker #(
  parameter int W  = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  s,
  input  logic [W-1:0]  t,
  input  logic [W-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sat,
  output logic          ic,
  output logic          err,
  input  logic          clr,
  output logic [CW-1:0] chk_cnt,
  output logic [CW-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  state_e state_q, state_d;

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  s_q, s_d;
  logic [W-1:0]  t_q, t_d;
  logic [IW-1:0] idx_q, idx_d;

  logic dA_q, dA_d, gA_q, gA_d;
  logic dS_q, dS_d, gS_q, gS_d;

  logic sat_q, sat_d;
  logic ic_q, ic_d;
  logic err_q, err_d;
  logic vld_q, vld_d;

  logic [CW-1:0] chk_cnt_q;
  logic [CW-1:0] err_cnt_q;

  logic ab, sb, tb;
  logic dA_n, gA_n, dS_n, gS_n;
  logic hs;

  assign ab = a_q[W-1];
  assign sb = s_q[W-1];
  assign tb = t_q[W-1];

  // First differing bit decides; later bits cannot change it.
  assign dA_n = dA_q | (ab ^ tb);
  assign gA_n = (!dA_q && (ab ^ tb)) ? ab : gA_q;
  assign dS_n = dS_q | (sb ^ tb);
  assign gS_n = (!dS_q && (sb ^ tb)) ? sb : gS_q;

  assign hs = (state_q == DONE) & vld_q & out_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    s_d     = s_q;
    t_d     = t_q;
    idx_d   = idx_q;
    dA_d    = dA_q;
    gA_d    = gA_q;
    dS_d    = dS_q;
    gS_d    = gS_q;
    sat_d   = sat_q;
    ic_d    = ic_q;
    err_d   = err_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = x & s;
          s_d     = s;
          t_d     = t;
          idx_d   = IW'(W - 1);
          dA_d    = 1'b0;
          gA_d    = 1'b0;
          dS_d    = 1'b0;
          gS_d    = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        dA_d  = dA_n;
        gA_d  = gA_n;
        dS_d  = dS_n;
        gS_d  = gS_n;
        a_d   = a_q << 1;
        s_d   = s_q << 1;
        t_d   = t_q << 1;
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          sat_d   = ~dA_n | gA_n;
          ic_d    = ~dS_n | gS_n;
          err_d   = (~dS_n | gS_n) & ~(~dA_n | gA_n);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Result is presented one cycle after entering DONE.
        vld_d = 1'b1;
        if (hs) begin
          vld_d   = 1'b0;
          sat_d   = 1'b0;
          ic_d    = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      s_q     <= '0;
      t_q     <= '0;
      idx_q   <= '0;
      dA_q    <= 1'b0;
      gA_q    <= 1'b0;
      dS_q    <= 1'b0;
      gS_q    <= 1'b0;
      sat_q   <= 1'b0;
      ic_q    <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      s_q     <= s_d;
      t_q     <= t_d;
      idx_q   <= idx_d;
      dA_q    <= dA_d;
      gA_q    <= gA_d;
      dS_q    <= dS_d;
      gS_q    <= gS_d;
      sat_q   <= sat_d;
      ic_q    <= ic_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (clr) begin
      chk_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (hs) begin
      if (chk_cnt_q != '1) begin
        chk_cnt_q <= chk_cnt_q + 1'b1;
      end
      if (err_q && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = vld_q;
  assign sat       = sat_q & vld_q;
  assign ic        = ic_q & vld_q;
  assign err       = err_q & vld_q;
  assign chk_cnt   = chk_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ic_bvuge_bvand_checker.sv
// Randomized bench for ic_bvuge_bvand_checker against an arithmetic model.
// Drives W=4 (CW=16 and CW=2 in parallel) and a W=1 instance.
module tb_ic_bvuge_bvand_checker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic       clr;
  logic [3:0] s, t, x;

  logic        in_ready, out_valid, sat, ic, err;
  logic [15:0] chk_cnt, err_cnt;
  logic        in_ready2, out_valid2, sat2, ic2, err2;
  logic [1:0]  chk_cnt2, err_cnt2;

  logic        iv1, or1, ir1, ov1, sat1, ic1, err1;
  logic [0:0]  s1, t1, x1;
  logic [15:0] chk1, errc1;

  int tests;
  int fails;
  int chk_m, err_m, chk2_m, err2_m;

  ic_bvuge_bvand_checker #(.W(4), .CW(16)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .t(t), .x(x),
    .out_valid(out_valid), .out_ready(out_ready),
    .sat(sat), .ic(ic), .err(err),
    .clr(clr), .chk_cnt(chk_cnt), .err_cnt(err_cnt)
  );

  ic_bvuge_bvand_checker #(.W(4), .CW(2)) u4c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .s(s), .t(t), .x(x),
    .out_valid(out_valid2), .out_ready(out_ready),
    .sat(sat2), .ic(ic2), .err(err2),
    .clr(clr), .chk_cnt(chk_cnt2), .err_cnt(err_cnt2)
  );

  ic_bvuge_bvand_checker #(.W(1), .CW(16)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1),
    .s(s1), .t(t1), .x(x1),
    .out_valid(ov1), .out_ready(or1),
    .sat(sat1), .ic(ic1), .err(err1),
    .clr(clr), .chk_cnt(chk1), .err_cnt(errc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_txn(input logic [3:0] si, input logic [3:0] ti,
                         input logic [3:0] xi, input int hold,
                         input bit doclr, input string tag);
    int lat;
    logic es, ei, ee;
    es = (int'(xi & si) >= int'(ti));
    ei = (int'(si) >= int'(ti));
    ee = ei & ~es;
    tests++;
    if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
      fails++;
      $display("FAIL %s in_ready: got %b/%b want 1", tag, in_ready, in_ready2);
    end
    s = si; t = ti; x = xi;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    s = 4'($urandom); t = 4'($urandom); x = 4'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tests++;
      if ({sat, ic, err, in_ready} !== 4'b0) begin
        fails++;
        $display("FAIL %s busy_outs: got %b want 0000", tag, {sat, ic, err, in_ready});
      end
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    tests++;
    if (lat != 5) begin
      fails++;
      $display("FAIL %s latency: got %0d want 5", tag, lat);
    end
    for (int i = 0; i <= hold; i++) begin
      tests++;
      if ({out_valid, sat, ic, err, in_ready} !== {1'b1, es, ei, ee, 1'b0} ||
          {out_valid2, sat2, ic2, err2} !== {1'b1, es, ei, ee}) begin
        fails++;
        $display("FAIL %s result: got v%b sat%b ic%b err%b rdy%b want v1 sat%b ic%b err%b rdy0",
                 tag, out_valid, sat, ic, err, in_ready, es, ei, ee);
      end
      if (i < hold) begin
        in_valid = 1'($urandom);
        s = 4'($urandom); t = 4'($urandom); x = 4'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr = doclr;
    @(posedge clk); #1;
    out_ready = 1'b0;
    clr = 1'b0;
    if (doclr) begin
      chk_m = 0; err_m = 0; chk2_m = 0; err2_m = 0;
    end else begin
      if (chk_m < 65535) chk_m++;
      if (ee && err_m < 65535) err_m++;
      if (chk2_m < 3) chk2_m++;
      if (ee && err2_m < 3) err2_m++;
    end
    tests++;
    if ({out_valid, sat, ic, err, in_ready} !== 5'b00001) begin
      fails++;
      $display("FAIL %s after_hs: got %b want 00001", tag, {out_valid, sat, ic, err, in_ready});
    end
    tests++;
    if (chk_cnt !== 16'(chk_m) || err_cnt !== 16'(err_m)) begin
      fails++;
      $display("FAIL %s counters: got %0d,%0d want %0d,%0d", tag, chk_cnt, err_cnt, chk_m, err_m);
    end
    tests++;
    if (chk_cnt2 !== 2'(chk2_m) || err_cnt2 !== 2'(err2_m)) begin
      fails++;
      $display("FAIL %s counters_cw2: got %0d,%0d want %0d,%0d", tag, chk_cnt2, err_cnt2, chk2_m, err2_m);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, sat, ic, err} !== 5'b10000 || chk_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: got rdy%b v%b %b%b%b cnt %0d,%0d want rdy1 v0 000 cnt 0,0",
               in_ready, out_valid, sat, ic, err, chk_cnt, err_cnt);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_m = 0; err_m = 0; chk2_m = 0; err2_m = 0;
  endtask

  task automatic test_directed();
    run_txn(4'b1111, 4'b0101, 4'b0101, 0, 1'b0, "pass_basic");
    run_txn(4'b1100, 4'b0100, 4'b0011, 0, 1'b0, "witness_err");
    run_txn(4'b0011, 4'b0100, 4'b1111, 0, 1'b0, "no_ic");
    run_txn(4'b1000, 4'b1000, 4'b1000, 0, 1'b0, "all_equal");
    run_txn(4'b0111, 4'b1000, 4'b0101, 0, 1'b0, "msb_decided");
  endtask

  task automatic test_backpressure();
    run_txn(4'b1100, 4'b0100, 4'b0011, 6, 1'b0, "bp_err");
    run_txn(4'b1010, 4'b0010, 4'b0110, 6, 1'b0, "bp_pass");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn(4'($urandom), 4'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)), 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid();
    s = 4'b1100; t = 4'b0100; x = 4'b0011;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_m = 0; err_m = 0; chk2_m = 0; err2_m = 0;
    tests++;
    if ({in_ready, out_valid, sat, ic, err} !== 5'b10000 || chk_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid: got rdy%b v%b %b%b%b cnt %0d,%0d want rdy1 v0 000 cnt 0,0",
               in_ready, out_valid, sat, ic, err, chk_cnt, err_cnt);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(4'b1111, 4'b0101, 4'b0101, 1, 1'b0, "after_reset");
  endtask

  task automatic test_saturate_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk_m = 0; err_m = 0; chk2_m = 0; err2_m = 0;
    tests++;
    if (chk_cnt2 !== 2'd0 || chk_cnt !== 16'd0) begin
      fails++;
      $display("FAIL clr_idle: got %0d,%0d want 0,0", chk_cnt2, chk_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      run_txn(4'b1100, 4'b0100, 4'b0011, 0, 1'b0, "sat_fill");
    end
    tests++;
    if (chk_cnt2 !== 2'd3 || err_cnt2 !== 2'd3) begin
      fails++;
      $display("FAIL sat_before_clr: got %0d,%0d want 3,3", chk_cnt2, err_cnt2);
    end
    run_txn(4'b1100, 4'b0100, 4'b0011, 0, 1'b1, "clr_on_hs");
    tests++;
    if (chk_cnt2 !== 2'd0 || err_cnt2 !== 2'd0) begin
      fails++;
      $display("FAIL sat_after_clr: got %0d,%0d want 0,0", chk_cnt2, err_cnt2);
    end
  endtask

  task automatic test_w1();
    int lat;
    int n;
    logic es, ei, ee;
    n = 0;
    for (int v = 0; v < 8; v++) begin
      s1 = 1'(v >> 2); t1 = 1'(v >> 1); x1 = 1'(v);
      es = (int'(x1 & s1) >= int'(t1));
      ei = (int'(s1) >= int'(t1));
      ee = ei & ~es;
      iv1 = 1'b1;
      or1 = 1'b0;
      @(posedge clk); #1;
      iv1 = 1'b0;
      s1 = ~s1; t1 = ~t1; x1 = ~x1;
      lat = 0;
      while (ov1 !== 1'b1 && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      tests++;
      if (lat != 2 || {sat1, ic1, err1} !== {es, ei, ee}) begin
        fails++;
        $display("FAIL w1_case%0d: got lat%0d %b%b%b want lat2 %b%b%b",
                 v, lat, sat1, ic1, err1, es, ei, ee);
      end
      or1 = 1'b1;
      @(posedge clk); #1;
      or1 = 1'b0;
      n++;
      tests++;
      if (ir1 !== 1'b1 || chk1 !== 16'(n)) begin
        fails++;
        $display("FAIL w1_hs%0d: got rdy%b cnt%0d want rdy1 cnt%0d", v, ir1, chk1, n);
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    s = '0; t = '0; x = '0;
    iv1 = 1'b0; or1 = 1'b0; s1 = '0; t1 = '0; x1 = '0;
    chk_m = 0; err_m = 0; chk2_m = 0; err2_m = 0;
    rst_n = 1'b1;
    #3;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_saturate_clr();
    test_w1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ic_bvuge_bvand_checker.md
IC_BVUGE_BVAND_CHECKER -- requirements
Module: ic_bvuge_bvand_checker

Interface
REQ-001 Parameter W, default 4: bit width of the s, t and x operands; legal range 1..32.
REQ-002 Parameter CW, default 16: width of the statistics counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand triple {s,t,x} is presented.
REQ-006 in_ready  output  1  checker can accept a triple.
REQ-007 s  input  W  constant operand of the constraint (x & s) >=u t.
REQ-008 t  input  W  bound operand of the constraint.
REQ-009 x  input  W  candidate witness produced by the Skolem function.
REQ-010 out_valid  output  1  result fields are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sat  output  1  (x & s) >=u t holds.
REQ-013 ic  output  1  invertibility condition s >=u t holds, i.e. some x exists.
REQ-014 err  output  1  ic & ~sat: a solution exists but the witness fails.
REQ-015 clr  input  1  synchronous clear of both counters.
REQ-016 chk_cnt  output  CW  number of completed result handshakes, saturating.
REQ-017 err_cnt  output  CW  number of completed result handshakes with err=1, saturating.

Function
REQ-018 The FSM SHALL have three states: IDLE, SHIFT, DONE; in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-019 IDLE: on in_valid&in_ready, latch a=x&s, s and t into shift registers, set the bit index to W-1, clear both compare flag pairs, and go to SHIFT.
REQ-020 SHIFT: each cycle, process one bit MSB-first for two serial unsigned compares, a vs t and s vs t.
REQ-021 Per-bit compare rule: if the pair's decided flag is 0 and the operand bits differ, set decided=1 and gt=operand bit; otherwise the pair holds its flags.
REQ-022 SHIFT SHALL last exactly W cycles with no early exit, even when both compares are decided early; after bit 0, go to DONE.
REQ-023 On entry to DONE, register sat=~dA|gA, ic=~dS|gS and err=ic&~sat; equal operands give uge=1.
REQ-024 Latency: out_valid rises exactly W+1 clock edges after the accepting edge.
REQ-025 DONE: sat, ic and err SHALL hold stable while out_ready=0; on out_valid&out_ready, go to IDLE, so in_ready=1 on the following cycle (no input/output overlap).
REQ-026 in_valid while not in IDLE SHALL be ignored, and operand changes after acceptance SHALL NOT affect the result.
REQ-027 On a result handshake, chk_cnt SHALL increment, and err_cnt SHALL increment if err=1; both saturate at 2^CW-1 and never wrap.
REQ-028 clr SHALL take priority over a same-cycle increment, leaving the counters 0; clr SHALL NOT affect the FSM.
REQ-029 sat, ic and err SHALL be 0 whenever out_valid=0.
REQ-030 W=1 SHALL work: a single SHIFT cycle, latency 2.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, sat=ic=err=0, chk_cnt=err_cnt=0, and clear shift registers and flags, regardless of clock.
REQ-032 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation with no counter update; the first accept after deassertion behaves as from power-up.

Verification (W=4)
REQ-033 s=1111,t=0101,x=0101, out_ready=1 -> out_valid 5 edges after accept, sat=1, ic=1, err=0, chk_cnt=1, err_cnt=0.
REQ-034 s=1100,t=0100,x=0011 -> sat=0, ic=1, err=1, err_cnt increments; then s=0011,t=0100,x=1111 -> sat=0, ic=0, err=0, err_cnt unchanged.
REQ-035 Equality/MSB cases: s=t=x=1000 -> sat=1, ic=1; s=0111,t=1000 -> ic=0, decided at the first bit, yet latency still 5.
REQ-036 Backpressure: hold out_ready=0 for 6 cycles in DONE and toggle the inputs -> outputs stable, in_ready=0, one count per handshake.
REQ-037 Reset pulse 2 cycles into SHIFT -> all outputs return to reset values asynchronously, no count; a new triple then completes normally.
REQ-038 CW=2: issue 5 failing checks with clr asserted on the 5th handshake -> counters read 3,3 before it and 0,0 after.
